fifo_wr_arbiter: RTL and testbench

//   Round-robin arbiter that shares the single write port of one synchronous fifo

---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side bundle for the shared fifo write port: per-requester word/last/data
// going in, one-hot ack/grant plus the fifo write strobe and data coming out.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_SZ = 8
);
  logic [NUM_REQ-1:0]         i_req;
  logic [NUM_REQ-1:0]         i_last;
  logic [NUM_REQ*DATA_SZ-1:0] i_data;
  logic                       i_full;
  logic [NUM_REQ-1:0]         o_ack;
  logic [NUM_REQ-1:0]         o_grant;
  logic                       o_wr;
  logic [DATA_SZ-1:0]         o_data;
  logic                       o_busy;

  modport slave (
    input  i_req, i_last, i_data, i_full,
    output o_ack, o_grant, o_wr, o_data, o_busy
  );

  modport master (
    output i_req, i_last, i_data, i_full,
    input  o_ack, o_grant, o_wr, o_data, o_busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of a single fifo write port: a winner keeps the port until its
// last word, a MAX_BURST cap, or it drops its request; one IDLE bubble between grants.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SZ   = 8,
  parameter int MAX_BURST = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      g_q, g_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [PW-1:0]      pick, scan;
  logic               found;
  logic               req_g, last_g, acc, rel;

  // Explicit wrap so non-power-of-2 NUM_REQ never indexes past the last requester.
  function automatic logic [PW-1:0] idx_inc(input logic [PW-1:0] idx);
    return (idx == IDX_LAST) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    scan  = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.i_req[scan]) begin
        pick  = scan;
        found = 1'b1;
      end
      scan = idx_inc(scan);
    end
  end

  assign req_g  = bus.i_req[g_q];
  assign last_g = bus.i_last[g_q];
  assign acc    = (state_q == GRANT) && req_g && !bus.i_full;
  assign rel    = acc && (last_g || (cnt_q == CNT_LAST));

  assign bus.o_wr    = acc;
  assign bus.o_ack   = acc ? grant_q : '0;
  assign bus.o_grant = grant_q;
  assign bus.o_busy  = (state_q == GRANT);

  always_comb begin
    bus.o_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (g_q == PW'(k)) bus.o_data = bus.i_data[k*DATA_SZ +: DATA_SZ];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = NUM_REQ'(1) << pick;
          g_d     = pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // Abandon and normal release both hand the pointer to the next requester.
        if (rel || !req_g) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = idx_inc(g_q);
        end else if (acc) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table for reset/round-robin/stall,
// hand sequences for burst cap, long stall, abandon and async reset mid-packet.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_SZ(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_SZ(DW), .MAX_BURST(MB)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic       full;
    logic [3:0] grant;
    logic       wr;
    logic [3:0] ack;
    logic       busy;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];
  int   bursts[$];
  logic [7:0] fifo_q[$];
  int   stall_seen;

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                              input logic fl, input logic [3:0] gr, input logic w,
                              input logic [3:0] ak, input logic bz, input logic [7:0] d);
    vec_t v;
    v.rst_n = r; v.req = rq; v.last = ls; v.full = fl;
    v.grant = gr; v.wr = w; v.ack = ak; v.busy = bz; v.data = d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic f);
    @(negedge clk);
    bus.i_req = r; bus.i_last = l; bus.i_full = f;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.i_req = '0; bus.i_last = '0; bus.i_full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int get_burst(input int i);
    return (bursts.size() > i) ? bursts[i] : -1;
  endfunction

  // Producer k streams nwords (last on the final one); i_full held stall_len cycles at word stall_at.
  task automatic run_pkt(input int k, input int nwords, input int stall_at, input int stall_len);
    int   sent, curlen, c;
    logic prev_busy;
    logic [3:0] oh;
    sent = 0; curlen = 0; prev_busy = 1'b0; stall_seen = 0;
    oh = 4'(1 << k);
    bursts.delete(); fifo_q.delete();
    bus.i_data = {NR{8'hEE}};
    for (c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.i_req  = (sent < nwords) ? oh : 4'b0;
      bus.i_last = (sent == nwords - 1) ? oh : 4'b0;
      bus.i_full = (sent == stall_at) && (stall_seen < stall_len);
      bus.i_data[k*DW +: DW] = sent[7:0];
      #1;
      if (bus.i_full) begin
        stall_seen++;
        chk("stall_wr", bus.o_wr, 0);
        chk("stall_ack", bus.o_ack, 0);
        chk("stall_grant", bus.o_grant, oh);
      end
      if (bus.o_wr) begin
        chk("pkt_data", bus.o_data, sent[7:0]);
        chk("pkt_ack", bus.o_ack, oh);
        fifo_q.push_back(bus.o_data);
        sent++; curlen++;
      end
      if (prev_busy && !bus.o_busy) begin
        bursts.push_back(curlen);
        curlen = 0;
      end
      prev_busy = bus.o_busy;
      if (sent >= nwords && !bus.o_busy) break;
    end
    chk("pkt_timeout", (c < 400) ? 1 : 0, 1);
  endtask

  task automatic chk_fifo(input int n);
    int bad;
    bad = 0;
    chk("fifo_count", fifo_q.size(), n);
    foreach (fifo_q[i]) if (fifo_q[i] != 8'(i)) bad++;
    chk("fifo_order", bad, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req = '0; bus.i_last = '0; bus.i_full = 1'b0;
    bus.i_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // rst, req, last, full | grant, wr, ack, busy, data
    vecs.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(1, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(1, 4'h1, 4'h1, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(1, 4'h1, 4'h1, 0, 4'h1, 1, 4'h1, 1, 8'hA0));
    vecs.push_back(mk(1, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 4'h1, 1, 4'h1, 1, 8'hA0));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 4'h2, 1, 4'h2, 1, 8'hA1));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 4'h4, 1, 4'h4, 1, 8'hA2));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 4'h8, 1, 4'h8, 1, 8'hA3));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 4'h1, 1, 4'h1, 1, 8'hA0));
    vecs.push_back(mk(1, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(1, 4'h2, 4'h2, 1, 4'h0, 0, 4'h0, 0, 8'h00));
    vecs.push_back(mk(1, 4'h2, 4'h2, 1, 4'h2, 0, 4'h0, 1, 8'hA1));
    vecs.push_back(mk(1, 4'h2, 4'h2, 0, 4'h2, 1, 4'h2, 1, 8'hA1));
    vecs.push_back(mk(1, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 8'h00));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      bus.i_req = vecs[i].req; bus.i_last = vecs[i].last; bus.i_full = vecs[i].full;
      #1;
      chk($sformatf("row%0d_grant", i), bus.o_grant, vecs[i].grant);
      chk($sformatf("row%0d_wr", i), bus.o_wr, vecs[i].wr);
      chk($sformatf("row%0d_ack", i), bus.o_ack, vecs[i].ack);
      chk($sformatf("row%0d_busy", i), bus.o_busy, vecs[i].busy);
      if (vecs[i].busy) chk($sformatf("row%0d_data", i), bus.o_data, vecs[i].data);
    end

    // Burst cap: 40 words from requester 2 split 16/16/8.
    do_reset();
    run_pkt(2, 40, -1, 0);
    chk("cap_nbursts", bursts.size(), 3);
    chk("cap_b0", get_burst(0), 16);
    chk("cap_b1", get_burst(1), 16);
    chk("cap_b2", get_burst(2), 8);
    chk_fifo(40);

    // Long stall at word 4; a counter that advanced while stalled would cut the first burst short.
    do_reset();
    run_pkt(3, 20, 4, 5);
    chk("stall_cycles", stall_seen, 5);
    chk("stall_nbursts", bursts.size(), 2);
    chk("stall_b0", get_burst(0), 16);
    chk("stall_b1", get_burst(1), 4);
    chk_fifo(20);

    // Abandon: requester 1 drops after 3 words, pointer moves on to 2.
    do_reset();
    bus.i_data = {8'h33, 8'h22, 8'h11, 8'h00};
    cyc(4'b0010, 4'b0000, 0);
    chk("ab_idle_busy", bus.o_busy, 0);
    for (int w = 0; w < 3; w++) begin
      cyc(4'b0010, 4'b0000, 0);
      chk($sformatf("ab_w%0d_wr", w), bus.o_wr, 1);
      chk($sformatf("ab_w%0d_data", w), bus.o_data, 8'h11);
    end
    cyc(4'b0100, 4'b0000, 0);
    chk("ab_drop_wr", bus.o_wr, 0);
    chk("ab_drop_ack", bus.o_ack, 0);
    chk("ab_drop_grant", bus.o_grant, 4'b0010);
    cyc(4'b0110, 4'b0000, 0);
    chk("ab_bubble_busy", bus.o_busy, 0);
    cyc(4'b0110, 4'b0000, 0);
    chk("ab_next_grant", bus.o_grant, 4'b0100);
    chk("ab_next_data", bus.o_data, 8'h22);

    // Async reset mid-packet with pointer parked at 2; restart must pick requester 0.
    do_reset();
    cyc(4'b0010, 4'b0010, 0);
    cyc(4'b0010, 4'b0010, 0);
    chk("ar_r1_wr", bus.o_wr, 1);
    cyc(4'b0100, 4'b0000, 0);
    cyc(4'b0100, 4'b0000, 0);
    chk("ar_pre_grant", bus.o_grant, 4'b0100);
    chk("ar_pre_wr", bus.o_wr, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_grant", bus.o_grant, 0);
    chk("ar_wr", bus.o_wr, 0);
    chk("ar_ack", bus.o_ack, 0);
    chk("ar_busy", bus.o_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_req = 4'b0111; bus.i_last = 4'b0111;
    #1;
    chk("ar_idle_busy", bus.o_busy, 0);
    cyc(4'b0111, 4'b0111, 0);
    chk("ar_restart_grant", bus.o_grant, 4'b0001);
    chk("ar_restart_data", bus.o_data, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
